// File: rtl/counter_run_ctrl.sv
// rtl/counter_run_ctrl.sv - run sequencer for an external WIDTH-bit enable counter (option: COUNTER_RUN_CTRL_PERIODIC_EN)
module counter_run_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_limit,
`ifdef COUNTER_RUN_CTRL_PERIODIC_EN
    input  logic             cmd_periodic,
`endif
    input  logic             pause,
    input  logic             abort,
    output logic             cnt_rst,
    output logic             cnt_enable,
    input  logic [WIDTH-1:0] cnt_count,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] limit_q;
    logic             periodic_q;
    logic             done_q;
    logic             aborted_q;
    logic             periodic_in;
    logic             terminal;

`ifdef COUNTER_RUN_CTRL_PERIODIC_EN
    assign periodic_in = cmd_periodic;
`else
    assign periodic_in = 1'b0;
`endif

    // >= rather than == so a counter that somehow overshoots still terminates
    assign terminal = (cnt_count >= limit_q);

    // Sequencer: accept, clear the counter, run to the limit, report
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            limit_q    <= '0;
            periodic_q <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // abort is deliberately ignored here; a command may land alongside it
                    if (cmd_valid) begin
                        limit_q    <= cmd_limit;
                        periodic_q <= periodic_in;
                        state      <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (abort) begin
                        aborted_q <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // abort outranks terminal detection in the same cycle
                    if (abort) begin
                        aborted_q <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (terminal) begin
                        done_q <= 1'b1;
                        state  <= periodic_q ? ST_CLEAR : ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = !rst && (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign cnt_rst    = rst || (state == ST_CLEAR);
    // enable drops as soon as count reaches the limit, so limit = max never wraps
    assign cnt_enable = (state == ST_RUN) && !pause && !abort && !terminal;
    assign done       = done_q;
    assign aborted    = aborted_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// tb/tb_counter_run_ctrl.sv - self-checking bench for counter_run_ctrl with an attached enable counter
module tb_counter_run_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_limit;
    logic       periodic_in;
    logic       pause;
    logic       abort;
    logic       cnt_rst;
    logic       cnt_enable;
    logic [7:0] cnt_count;
    logic       busy;
    logic       done;
    logic       aborted;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    counter_run_ctrl #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_limit  (cmd_limit),
`ifdef COUNTER_RUN_CTRL_PERIODIC_EN
        .cmd_periodic(periodic_in),
`endif
        .pause      (pause),
        .abort      (abort),
        .cnt_rst    (cnt_rst),
        .cnt_enable (cnt_enable),
        .cnt_count  (cnt_count),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted)
    );

    // the controlled 8-bit enable counter
    always @(posedge clk) begin
        if (cnt_rst)         cnt_count <= 8'd0;
        else if (cnt_enable) cnt_count <= cnt_count + 8'd1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // reference: a command owes N enable grants after the clear cycle
    bit m_busy = 0, m_clear = 0, m_run = 0, m_fin = 0, m_done = 0, m_ab = 0, m_per = 0;
    int owed = 0, m_lim = 0, m_count = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_en, n_done, n_ab;
            exp_en = m_run && !pause && !abort && (owed > 0);
            chk("cmd_ready", cmd_ready, !rst && !m_busy);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("aborted", aborted, m_ab);
            chk("cnt_rst", cnt_rst, rst || m_clear);
            if (!rst) chk("cnt_enable", cnt_enable, exp_en);
            chk("cnt_count", cnt_count, m_count);
            if (rst) begin
                m_busy = 0; m_clear = 0; m_run = 0; m_fin = 0; m_done = 0; m_ab = 0;
                owed = 0; m_count = 0;
            end else begin
                n_done = 0;
                n_ab = 0;
                if (m_clear) m_count = 0;
                else if (exp_en) m_count = m_count + 1;
                if (!m_busy) begin
                    if (cmd_valid) begin
                        m_busy = 1; m_clear = 1; owed = cmd_limit; m_lim = cmd_limit; m_per = periodic_in;
                    end
                end else if (m_fin) begin
                    m_busy = 0; m_fin = 0;
                end else if (abort) begin
                    m_busy = 0; m_clear = 0; m_run = 0; n_ab = 1;
                end else if (m_clear) begin
                    m_clear = 0; m_run = 1;
                end else if (owed == 0) begin
                    m_run = 0; n_done = 1;
                    if (m_per) begin m_clear = 1; owed = m_lim; end
                    else m_fin = 1;
                end else if (exp_en) begin
                    owed = owed - 1;
                end
                m_done = n_done;
                m_ab = n_ab;
            end
        end
    end

    // issue one command; cycle 1 is the cycle after the accepting edge
    task automatic run_cmd(input logic [7:0] lim, input int p_start, input int p_len, input int ab_cyc,
                           input bit junk, output int done_c, output int ab_c, output int en_n,
                           output int fcnt);
        int cyc;
        done_c = 0; ab_c = 0; en_n = 0; fcnt = -1;
        cmd_valid = 1'b1;
        cmd_limit = lim;
        abort = (ab_cyc == 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 1;
        while (1) begin
            pause = (cyc >= p_start) && (cyc < p_start + p_len);
            abort = (cyc == ab_cyc);
            if (junk) begin
                cmd_valid = (cyc >= 2) && (cyc <= 4);
                cmd_limit = 8'd200;
            end
            @(negedge clk);
            if (cnt_enable) en_n++;
            if (done) done_c = cyc;
            if (aborted) ab_c = cyc;
            if (done || aborted || cyc >= 600) break;
            @(posedge clk); #1;
            cyc++;
        end
        fcnt = cnt_count;
        @(posedge clk); #1;
        pause = 1'b0; abort = 1'b0; cmd_valid = 1'b0;
    endtask

    initial begin
        int dc, ac, en, fc;
        rst = 1'b1; cmd_valid = 1'b0; cmd_limit = 8'd0; periodic_in = 1'b0; pause = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk("rst_cnt_rst", cnt_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", cmd_ready, 1);

        run_cmd(8'd5, 0, 0, -1, 0, dc, ac, en, fc);
        chk("n5_done_cycle", dc, 8);
        chk("n5_enables", en, 5);
        chk("n5_count", fc, 5);
        chk("n5_ready_after", cmd_ready, 1);

        run_cmd(8'd10, 5, 3, -1, 0, dc, ac, en, fc);
        chk("pause_done_cycle", dc, 16);
        chk("pause_enables", en, 10);
        chk("pause_count", fc, 10);

        run_cmd(8'd20, 0, 0, 9, 0, dc, ac, en, fc);
        chk("abort_pulse_cycle", ac, 10);
        chk("abort_no_done", dc, 0);
        chk("abort_enables", en, 7);
        chk("abort_count_held", fc, 7);
        chk("abort_ready_after", cmd_ready, 1);

        run_cmd(8'd0, 0, 0, -1, 0, dc, ac, en, fc);
        chk("n0_done_cycle", dc, 3);
        chk("n0_enables", en, 0);

        run_cmd(8'd255, 0, 0, -1, 0, dc, ac, en, fc);
        chk("n255_done_cycle", dc, 258);
        chk("n255_enables", en, 255);
        chk("n255_count", fc, 255);

        run_cmd(8'd4, 0, 0, -1, 1, dc, ac, en, fc);
        chk("busy_cmd_done_cycle", dc, 7);
        chk("busy_cmd_enables", en, 4);
        chk("busy_cmd_count", fc, 4);

        run_cmd(8'd2, 0, 0, 0, 0, dc, ac, en, fc);
        chk("idle_abort_done_cycle", dc, 5);
        chk("idle_abort_no_pulse", ac, 0);

        cmd_valid = 1'b1; cmd_limit = 8'd30;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_count", cnt_count, 0);
        repeat (3) @(posedge clk);
        #1;

`ifdef COUNTER_RUN_CTRL_PERIODIC_EN
        begin
            int cyc, np;
            periodic_in = 1'b1; cmd_valid = 1'b1; cmd_limit = 8'd3;
            @(posedge clk); #1;
            cmd_valid = 1'b0; periodic_in = 1'b0;
            cyc = 1; np = 0;
            while (cyc <= 22) begin
                abort = (cyc == 22);
                @(negedge clk);
                if (done) np++;
                @(posedge clk); #1;
                cyc++;
            end
            abort = 1'b0;
            chk("per_done_pulses", np, 4);
            chk("per_aborted", aborted, 1);
            chk("per_ready_after", cmd_ready, 1);
            @(posedge clk); #1;
        end
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
